abc_sweep_sequencer: RTL and testbench

- Sequential stimulus/capture stage wrapped around a small combinational function block (3-input Y logic).
- Upstream: drives the N_IN-bit input vector {A,B,C} through every code in a selectable order.
- Downstream: samples the block's single-bit output after a settle interval and assembles the full truth table.
- Used for on-chip self-characterisation of the combinational stages.

---
 rtl/abc_sweep_pkg.sv | 19 +
 rtl/abc_code_map.sv | 21 ++
 rtl/abc_sweep_sequencer.sv | 129 ++++++++++++
 tb/tb_abc_sweep_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/abc_sweep_pkg.sv
// Shared definitions for the ABC sweep stages: FSM states, sweep modes, table width.
package abc_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;

    function automatic int tbl_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/abc_code_map.sv
// Combinational step -> driven code mapping for up, down and Gray sweep orders.
module abc_code_map
    import abc_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] step_i,
    input  logic [1:0]      mode_i,
    output logic [N_IN-1:0] code_o
);

    always_comb begin
        code_o = step_i;
        case (mode_i)
            MODE_DOWN: code_o = ~step_i;
            MODE_GRAY: code_o = step_i ^ (step_i >> 1);
            default:   code_o = step_i;  // reserved mode sweeps upward
        endcase
    end

endmodule

// File: rtl/abc_sweep_sequencer.sv
// Drives every input code into a combinational block and captures its truth table.
// Optional SWEEP_COMPARE_EN adds a golden-table compare reported with done.
module abc_sweep_sequencer
    import abc_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic                      y_i,
`ifdef SWEEP_COMPARE_EN
    input  logic [tbl_w(N_IN)-1:0]    expected_i,
    output logic                      match,
    output logic [tbl_w(N_IN)-1:0]    mismatch_mask,
`endif
    output logic [N_IN-1:0]           abc_o,
    output logic                      busy,
    output logic                      done,
    output logic [tbl_w(N_IN)-1:0]    table_o
);

    localparam int              TW        = tbl_w(N_IN);
    localparam logic [N_IN-1:0] STEP_LAST = {N_IN{1'b1}};
    localparam logic [3:0]      CNT_LAST  = 4'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] step_q, step_d;
    logic [1:0]      mode_q, mode_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tbl_q, tbl_d;
    logic [N_IN-1:0] abc_q, abc_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    tbl_d   = '0;
                    step_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            ST_SAMPLE: begin
                tbl_d[abc_q] = y_i;
                if (step_q == STEP_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // step/mode only move together with the vector, so the code is a pure function of them
    abc_code_map #(.N_IN(N_IN)) u_code_map (
        .step_i (step_d),
        .mode_i (mode_d),
        .code_o (abc_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            mode_q  <= MODE_UP;
            cnt_q   <= '0;
            tbl_q   <= '0;
            abc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            abc_q   <= abc_d;
        end
    end

    assign abc_o   = abc_q;
    assign table_o = tbl_q;
    assign busy    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done    = (state_q == ST_DONE);

`ifdef SWEEP_COMPARE_EN
    logic          match_q, match_d;
    logic [TW-1:0] mask_q, mask_d;

    // compare against the final table as it is written, so results are valid during done
    always_comb begin
        match_d = match_q;
        mask_d  = mask_q;
        if (state_d == ST_DONE) begin
            mask_d  = tbl_d ^ expected_i;
            match_d = (mask_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            match_q <= match_d;
            mask_q  <= mask_d;
        end
    end

    assign match         = match_q;
    assign mismatch_mask = mask_q;
`endif

endmodule

// File: tb/tb_abc_sweep_sequencer.sv
// Directed bench for abc_sweep_sequencer: expected code order queued per sweep, checked per cycle.
module tb_abc_sweep_sequencer;
    import abc_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, start, y_i;
    logic [1:0] mode;
    logic [2:0] abc_o;
    logic       busy, done;
    logic [7:0] table_o;
`ifdef SWEEP_COMPARE_EN
    logic [7:0] expected_i;
    logic       match;
    logic [7:0] mismatch_mask;
`endif

    int         fn_sel;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [2:0] code_q[$];

    always #5 clk = ~clk;

    abc_sweep_sequencer #(.N_IN(3), .SETTLE(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .y_i           (y_i),
`ifdef SWEEP_COMPARE_EN
        .expected_i    (expected_i),
        .match         (match),
        .mismatch_mask (mismatch_mask),
`endif
        .abc_o         (abc_o),
        .busy          (busy),
        .done          (done),
        .table_o       (table_o)
    );

    // function under test: 0 majority, 1 A&~B|C, 2 parity
    always_comb begin
        case (fn_sel)
            1:       y_i = (abc_o[2] & ~abc_o[1]) | abc_o[0];
            2:       y_i = ^abc_o;
            default: y_i = (abc_o[2] & abc_o[1]) | (abc_o[2] & abc_o[0]) | (abc_o[1] & abc_o[0]);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_code(input int k, input logic [1:0] m);
        case (m)
            2'b01:   return 3'(7 - k);
            2'b10:   return 3'(k ^ (k >> 1));
            default: return 3'(k);
        endcase
    endfunction

    // Starts a sweep on the next edge, then checks every cycle up to and including done.
    task automatic sweep(input logic [1:0] m, input int fn, input logic [7:0] exp_tbl,
                         input bit tamper, input bit hold);
        logic [2:0] c, prev;
        prev   = '0;
        fn_sel = fn;
        mode   = m;
        start  = 1'b1;
        for (int k = 0; k < 8; k++) code_q.push_back(ref_code(k, m));
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            c = code_q.pop_front();
            for (int s = 0; s < 3; s++) begin
                chk("abc_o", 32'(abc_o), 32'(c));
                chk("busy", 32'(busy), 32'd1);
                chk("done_low", 32'(done), 32'd0);
                if (k == 0 && s == 0) chk("table_cleared", 32'(table_o), 32'd0);
                if (m == MODE_GRAY && k > 0 && s == 0)
                    chk("gray_one_bit", 32'($countones(abc_o ^ prev)), 32'd1);
                if (tamper && k == 2 && s == 0) begin
                    start = 1'b1;
                    mode  = (m == MODE_DOWN) ? MODE_UP : MODE_DOWN;
                end
                if (tamper && k == 2 && s == 1) start = 1'b0;
                @(negedge clk);
            end
            prev = c;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("table_o", 32'(table_o), 32'(exp_tbl));
`ifdef SWEEP_COMPARE_EN
        chk("mismatch_mask", 32'(mismatch_mask), 32'(exp_tbl ^ expected_i));
        chk("match", 32'(match), 32'(exp_tbl == expected_i));
`endif
        mode = m;
        if (!hold) begin
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("table_hold", 32'(table_o), 32'(exp_tbl));
            chk("abc_hold", 32'(abc_o), 32'(c));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = MODE_UP;
        fn_sel = 0;
`ifdef SWEEP_COMPARE_EN
        expected_i = 8'hE8;
`endif
        repeat (2) @(negedge clk);
        chk("rst_abc", 32'(abc_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_table", 32'(table_o), 32'd0);
`ifdef SWEEP_COMPARE_EN
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_mask", 32'(mismatch_mask), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", 32'(busy), 32'd0);

        sweep(MODE_UP,   0, 8'hE8, 1'b0, 1'b0);
        sweep(MODE_DOWN, 1, 8'hBA, 1'b0, 1'b0);
        sweep(MODE_GRAY, 2, 8'h96, 1'b0, 1'b0);
        sweep(2'b11,     1, 8'hBA, 1'b0, 1'b0);
        sweep(MODE_UP,   0, 8'hE8, 1'b1, 1'b0);

`ifdef SWEEP_COMPARE_EN
        expected_i = 8'hE9;
        sweep(MODE_UP, 0, 8'hE8, 1'b0, 1'b0);
        chk("cmp_mask_e9", 32'(mismatch_mask), 32'h01);
        chk("cmp_match_e9", 32'(match), 32'd0);
        expected_i = 8'hE8;
`endif

        // start held high: one IDLE cycle, then a fresh sweep with a cleared table
        sweep(MODE_UP, 0, 8'hE8, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_done", 32'(done), 32'd0);
        chk("b2b_idle_table", 32'(table_o), 32'hE8);
        @(negedge clk);
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_restart_table", 32'(table_o), 32'd0);
        chk("b2b_restart_abc", 32'(abc_o), 32'd0);

        // reset in the middle of that sweep discards the partial table
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_abc", 32'(abc_o), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_table", 32'(table_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);

        sweep(MODE_GRAY, 0, 8'hE8, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
